// File: rtl/mul_pipe_ctrl_pkg.sv
// Shared definitions for the multiply pipeline sequencer: register address
// width, default pipeline depth and the per-stage token carried through M1..Mn.
package mul_pipe_ctrl_pkg;

  localparam int MUL_REG_ADDR = 5;
  localparam int MUL_DEPTH    = 5;

  typedef struct packed {
    logic                    valid;
    logic                    regwrite;
    logic [MUL_REG_ADDR-1:0] dst;
  } mul_token_t;

  // A token blocks decode when it will write a register that decode reads.
  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic tok_hits(input mul_token_t t,
                                    input logic [MUL_REG_ADDR-1:0] a,
                                    input logic [MUL_REG_ADDR-1:0] b);
    return t.valid & t.regwrite & (t.dst != '0) & ((t.dst == a) | (t.dst == b));
  endfunction

endpackage

// File: rtl/mul_token_stage.sv
// One token register of the multiply sequencer: loads when enabled, clear
// wins over load so a squash empties the stage regardless of stall.
module mul_token_stage
  import mul_pipe_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  mul_token_t d,
  output mul_token_t q
);

  // Token register with async reset, clear over enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/mul_pipe_ctrl.sv
// Multiply pipeline sequencer: tracks one valid/regwrite/dst token per stage,
// generates stage write enables, RAW-hazard detection for decode, and
// arbitration of the register-file write port (multiply wins over ALU).
// Optional squash support is compiled in with `define MUL_FLUSH_EN; without it
// the flush input is accepted but has no effect.
module mul_pipe_ctrl
  import mul_pipe_ctrl_pkg::*;
#(
  parameter int DEPTH    = MUL_DEPTH,
  parameter int REG_ADDR = MUL_REG_ADDR   // must equal the token dst width
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall_in,
  input  logic                       issue_valid,
  input  logic [REG_ADDR-1:0]        issue_wreg,
  input  logic                       issue_regwrite,
  output logic                       issue_ready,
  input  logic [REG_ADDR-1:0]        src_a,
  input  logic [REG_ADDR-1:0]        src_b,
  output logic                       raw_hazard,
  output logic [DEPTH-1:0]           stage_we,
  output logic [DEPTH-1:0]           stage_valid,
  output logic                       mul_wb_valid,
  output logic [REG_ADDR-1:0]        mul_wb_reg,
  input  logic                       alu_wb_req,
  output logic                       alu_wb_grant,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       busy,
  input  logic                       flush
);

  localparam int OCC_W = $clog2(DEPTH+1);

  mul_token_t       tok   [DEPTH];
  mul_token_t       tok_d [DEPTH];
  mul_token_t       issue_tok;
  logic             flush_eff;
  logic             accept;
  logic             retire;
  logic [OCC_W-1:0] occ_q;

`ifdef MUL_FLUSH_EN
  assign flush_eff = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_eff    = 1'b0;
`endif

  // A squash blocks issue in the same cycle so nothing new survives it.
  assign issue_ready = ~stall_in & ~flush_eff;
  assign accept      = issue_valid & issue_ready;
  assign retire      = ~stall_in & tok[DEPTH-1].valid;

  assign issue_tok.valid    = accept;
  assign issue_tok.regwrite = issue_regwrite;
  assign issue_tok.dst      = issue_wreg;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_first
      assign tok_d[g]    = issue_tok;
      assign stage_we[g] = accept;
    end else begin : g_rest
      assign tok_d[g]    = tok[g-1];
      assign stage_we[g] = ~stall_in & tok[g-1].valid;
    end

    mul_token_stage u_stage (
      .clk   (clk),
      .reset (reset),
      .en    (~stall_in),
      .clr   (flush_eff),
      .d     (tok_d[g]),
      .q     (tok[g])
    );

    assign stage_valid[g] = tok[g].valid;
  end

  // The last stage retires in a flush cycle too; only stall suppresses it.
  assign mul_wb_valid = ~stall_in & tok[DEPTH-1].valid & tok[DEPTH-1].regwrite;
  assign mul_wb_reg   = tok[DEPTH-1].dst;
  assign alu_wb_grant = alu_wb_req & ~mul_wb_valid;

  // Hazard scan covers every stage, including the last (no writeback bypass).
  always_comb begin
    raw_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tok_hits(tok[i], src_a, src_b)) raw_hazard = 1'b1;
    end
  end

  // In-flight counter: issue adds one, retirement removes one, squash empties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  occ_q <= '0;
    else if (flush_eff)         occ_q <= '0;
    else if (accept && !retire) occ_q <= occ_q + OCC_W'(1);
    else if (retire && !accept) occ_q <= occ_q - OCC_W'(1);
  end

  assign occupancy = occ_q;
  assign busy      = (occ_q != '0);

endmodule

// File: tb/tb_mul_pipe_ctrl.sv
// Directed self-checking bench for mul_pipe_ctrl (DEPTH=5, REG_ADDR=5).
module tb_mul_pipe_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall_in;
  logic       issue_valid;
  logic [4:0] issue_wreg;
  logic       issue_regwrite;
  logic       issue_ready;
  logic [4:0] src_a;
  logic [4:0] src_b;
  logic       raw_hazard;
  logic [4:0] stage_we;
  logic [4:0] stage_valid;
  logic       mul_wb_valid;
  logic [4:0] mul_wb_reg;
  logic       alu_wb_req;
  logic       alu_wb_grant;
  logic [2:0] occupancy;
  logic       busy;
  logic       flush;

  int total = 0;
  int bad   = 0;

  mul_pipe_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .stall_in       (stall_in),
    .issue_valid    (issue_valid),
    .issue_wreg     (issue_wreg),
    .issue_regwrite (issue_regwrite),
    .issue_ready    (issue_ready),
    .src_a          (src_a),
    .src_b          (src_b),
    .raw_hazard     (raw_hazard),
    .stage_we       (stage_we),
    .stage_valid    (stage_valid),
    .mul_wb_valid   (mul_wb_valid),
    .mul_wb_reg     (mul_wb_reg),
    .alu_wb_req     (alu_wb_req),
    .alu_wb_grant   (alu_wb_grant),
    .occupancy      (occupancy),
    .busy           (busy),
    .flush          (flush)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] r, input logic rw);
    issue_valid    = 1'b1;
    issue_wreg     = r;
    issue_regwrite = rw;
  endtask

  task automatic idle();
    issue_valid    = 1'b0;
    issue_wreg     = 5'd0;
    issue_regwrite = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall_in = 1'b0; flush = 1'b0;
    alu_wb_req = 1'b1; src_a = 5'd0; src_b = 5'd0;
    idle();
    #12;
    // reset state
    total++; if (issue_ready !== 1'b1) begin bad++; $error("FAIL rst_ready observed=%0h expected=%0h", issue_ready, 1'b1); end
    total++; if (alu_wb_grant !== 1'b1) begin bad++; $error("FAIL rst_grant observed=%0h expected=%0h", alu_wb_grant, 1'b1); end
    total++; if (stage_valid !== 5'b00000) begin bad++; $error("FAIL rst_valid observed=%0h expected=%0h", stage_valid, 5'b00000); end
    total++; if (occupancy !== 3'd0) begin bad++; $error("FAIL rst_occ observed=%0h expected=%0h", occupancy, 3'd0); end
    total++; if (busy !== 1'b0) begin bad++; $error("FAIL rst_busy observed=%0h expected=%0h", busy, 1'b0); end
    total++; if (mul_wb_valid !== 1'b0) begin bad++; $error("FAIL rst_wb observed=%0h expected=%0h", mul_wb_valid, 1'b0); end
    stall_in = 1'b1; #1;
    total++; if (issue_ready !== 1'b0) begin bad++; $error("FAIL rst_ready_stall observed=%0h expected=%0h", issue_ready, 1'b0); end
    stall_in = 1'b0; alu_wb_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // 1: single issue walks the pipe
    issue(5'd5, 1'b1); #1;
    total++; if (stage_we !== 5'b00001) begin bad++; $error("FAIL t1_we0 observed=%0h expected=%0h", stage_we, 5'b00001); end
    tick(); idle(); #1;
    for (int k = 1; k <= 5; k++) begin
      total++; if (stage_valid !== 5'(1 << (k-1))) begin bad++; $error("FAIL t1_walk observed=%0h expected=%0h", stage_valid, 5'(1 << (k-1))); end
      total++; if (mul_wb_valid !== (k == 5)) begin bad++; $error("FAIL t1_wbv observed=%0h expected=%0h", mul_wb_valid, (k == 5)); end
      total++; if (occupancy !== 3'd1) begin bad++; $error("FAIL t1_occ observed=%0h expected=%0h", occupancy, 3'd1); end
      if (k == 5) begin
        total++; if (mul_wb_reg !== 5'd5) begin bad++; $error("FAIL t1_wbreg observed=%0h expected=%0h", mul_wb_reg, 5'd5); end
      end
      tick();
    end
    total++; if (occupancy !== 3'd0) begin bad++; $error("FAIL t1_occ0 observed=%0h expected=%0h", occupancy, 3'd0); end
    total++; if (busy !== 1'b0) begin bad++; $error("FAIL t1_busy0 observed=%0h expected=%0h", busy, 1'b0); end

    // 2: back-to-back r1..r5
    for (int i = 1; i <= 5; i++) begin
      issue(5'(i), 1'b1);
      tick();
    end
    idle(); #1;
    total++; if (occupancy !== 3'd5) begin bad++; $error("FAIL t2_occ5 observed=%0h expected=%0h", occupancy, 3'd5); end
    total++; if (stage_valid !== 5'b11111) begin bad++; $error("FAIL t2_full observed=%0h expected=%0h", stage_valid, 5'b11111); end
    for (int i = 1; i <= 5; i++) begin
      total++; if (mul_wb_valid !== 1'b1) begin bad++; $error("FAIL t2_wbv observed=%0h expected=%0h", mul_wb_valid, 1'b1); end
      total++; if (mul_wb_reg !== 5'(i)) begin bad++; $error("FAIL t2_wbreg observed=%0h expected=%0h", mul_wb_reg, 5'(i)); end
      tick();
    end
    total++; if (occupancy !== 3'd0) begin bad++; $error("FAIL t2_occ0 observed=%0h expected=%0h", occupancy, 3'd0); end

    // 3: stall for 3 cycles with r7 in stage 2
    issue(5'd7, 1'b1); tick(); idle(); tick();
    stall_in = 1'b1;
    issue(5'd8, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (stage_we !== 5'b00000) begin bad++; $error("FAIL t3_we observed=%0h expected=%0h", stage_we, 5'b00000); end
      total++; if (issue_ready !== 1'b0) begin bad++; $error("FAIL t3_ready observed=%0h expected=%0h", issue_ready, 1'b0); end
      total++; if (stage_valid !== 5'b00010) begin bad++; $error("FAIL t3_frozen observed=%0h expected=%0h", stage_valid, 5'b00010); end
      tick();
    end
    stall_in = 1'b0; idle(); #1;
    total++; if (stage_valid !== 5'b00010) begin bad++; $error("FAIL t3_noissue observed=%0h expected=%0h", stage_valid, 5'b00010); end
    total++; if (stage_we !== 5'b00100) begin bad++; $error("FAIL t3_we1 observed=%0h expected=%0h", stage_we, 5'b00100); end
    for (int k = 5; k < 8; k++) begin
      total++; if (mul_wb_valid !== 1'b0) begin bad++; $error("FAIL t3_nowb observed=%0h expected=%0h", mul_wb_valid, 1'b0); end
      tick();
    end
    stall_in = 1'b1; #1;
    total++; if (mul_wb_valid !== 1'b0) begin bad++; $error("FAIL t3_wb_stalled observed=%0h expected=%0h", mul_wb_valid, 1'b0); end
    stall_in = 1'b0; #1;
    total++; if (mul_wb_valid !== 1'b1) begin bad++; $error("FAIL t3_wb8 observed=%0h expected=%0h", mul_wb_valid, 1'b1); end
    total++; if (mul_wb_reg !== 5'd7) begin bad++; $error("FAIL t3_wbreg observed=%0h expected=%0h", mul_wb_reg, 5'd7); end
    tick();

    // 4: write-port arbitration
    issue(5'd9, 1'b1); tick(); idle();
    tick(); tick(); tick();
    alu_wb_req = 1'b1; #1;
    total++; if (alu_wb_grant !== 1'b1) begin bad++; $error("FAIL t4_grant_free observed=%0h expected=%0h", alu_wb_grant, 1'b1); end
    tick();
    total++; if (mul_wb_valid !== 1'b1) begin bad++; $error("FAIL t4_mulwb observed=%0h expected=%0h", mul_wb_valid, 1'b1); end
    total++; if (alu_wb_grant !== 1'b0) begin bad++; $error("FAIL t4_grant_lost observed=%0h expected=%0h", alu_wb_grant, 1'b0); end
    tick();
    total++; if (alu_wb_grant !== 1'b1) begin bad++; $error("FAIL t4_grant_next observed=%0h expected=%0h", alu_wb_grant, 1'b1); end
    alu_wb_req = 1'b0;

    // 5: RAW hazard detection
    issue(5'd3, 1'b1); tick();
    issue(5'd0, 1'b1);
    src_a = 5'd3; src_b = 5'd0; #1;
    total++; if (raw_hazard !== 1'b1) begin bad++; $error("FAIL t5_hz_a observed=%0h expected=%0h", raw_hazard, 1'b1); end
    src_a = 5'd4; src_b = 5'd3; #1;
    total++; if (raw_hazard !== 1'b1) begin bad++; $error("FAIL t5_hz_b observed=%0h expected=%0h", raw_hazard, 1'b1); end
    src_a = 5'd4; src_b = 5'd2; #1;
    total++; if (raw_hazard !== 1'b0) begin bad++; $error("FAIL t5_hz_none observed=%0h expected=%0h", raw_hazard, 1'b0); end
    tick();
    issue(5'd6, 1'b0);
    src_a = 5'd0; src_b = 5'd0; #1;
    total++; if (raw_hazard !== 1'b0) begin bad++; $error("FAIL t5_hz_r0 observed=%0h expected=%0h", raw_hazard, 1'b0); end
    tick(); idle();
    src_a = 5'd6; #1;
    total++; if (raw_hazard !== 1'b0) begin bad++; $error("FAIL t5_hz_norw observed=%0h expected=%0h", raw_hazard, 1'b0); end
    tick(); tick(); #1;
    src_a = 5'd3; #1;
    total++; if (mul_wb_valid !== 1'b1) begin bad++; $error("FAIL t5_last_wb observed=%0h expected=%0h", mul_wb_valid, 1'b1); end
    total++; if (raw_hazard !== 1'b1) begin bad++; $error("FAIL t5_hz_last observed=%0h expected=%0h", raw_hazard, 1'b1); end
    tick(); tick(); tick();
    src_a = 5'd0;
    total++; if (occupancy !== 3'd0) begin bad++; $error("FAIL t5_drained observed=%0h expected=%0h", occupancy, 3'd0); end

    // 6: flush with r1 in the last stage, then async reset mid-flight
    issue(5'd1, 1'b1); tick();
    issue(5'd2, 1'b1); tick();
    issue(5'd3, 1'b1); tick();
    idle(); tick(); tick();
    total++; if (stage_valid !== 5'b11100) begin bad++; $error("FAIL t6_pre observed=%0h expected=%0h", stage_valid, 5'b11100); end
    flush = 1'b1; #1;
    total++; if (mul_wb_valid !== 1'b1) begin bad++; $error("FAIL t6_wb observed=%0h expected=%0h", mul_wb_valid, 1'b1); end
    total++; if (mul_wb_reg !== 5'd1) begin bad++; $error("FAIL t6_wbreg observed=%0h expected=%0h", mul_wb_reg, 5'd1); end
`ifdef MUL_FLUSH_EN
    issue(5'd10, 1'b1); #1;
    total++; if (issue_ready !== 1'b0) begin bad++; $error("FAIL t6_ready observed=%0h expected=%0h", issue_ready, 1'b0); end
    total++; if (stage_we[0] !== 1'b0) begin bad++; $error("FAIL t6_we0 observed=%0h expected=%0h", stage_we[0], 1'b0); end
    tick(); flush = 1'b0; idle(); #1;
    total++; if (stage_valid !== 5'b00000) begin bad++; $error("FAIL t6_flushed observed=%0h expected=%0h", stage_valid, 5'b00000); end
    total++; if (occupancy !== 3'd0) begin bad++; $error("FAIL t6_occ observed=%0h expected=%0h", occupancy, 3'd0); end
    issue(5'd1, 1'b1); tick();
    issue(5'd2, 1'b1); tick();
    idle(); tick(); tick(); tick();
    total++; if (stage_valid !== 5'b11000) begin bad++; $error("FAIL t6_refill observed=%0h expected=%0h", stage_valid, 5'b11000); end
`else
    total++; if (issue_ready !== 1'b1) begin bad++; $error("FAIL t6_ready observed=%0h expected=%0h", issue_ready, 1'b1); end
    tick(); flush = 1'b0; #1;
    total++; if (stage_valid !== 5'b11000) begin bad++; $error("FAIL t6_ignored observed=%0h expected=%0h", stage_valid, 5'b11000); end
    total++; if (occupancy !== 3'd2) begin bad++; $error("FAIL t6_occ observed=%0h expected=%0h", occupancy, 3'd2); end
`endif
    #2 reset = 1'b1; #1;
    total++; if (stage_valid !== 5'b00000) begin bad++; $error("FAIL t6_rst_valid observed=%0h expected=%0h", stage_valid, 5'b00000); end
    total++; if (occupancy !== 3'd0) begin bad++; $error("FAIL t6_rst_occ observed=%0h expected=%0h", occupancy, 3'd0); end
    total++; if (mul_wb_valid !== 1'b0) begin bad++; $error("FAIL t6_rst_wb observed=%0h expected=%0h", mul_wb_valid, 1'b0); end
    total++; if (busy !== 1'b0) begin bad++; $error("FAIL t6_rst_busy observed=%0h expected=%0h", busy, 1'b0); end
    tick();
    reset = 1'b0;
    tick();
    total++; if (stage_valid !== 5'b00000) begin bad++; $error("FAIL t6_after observed=%0h expected=%0h", stage_valid, 5'b00000); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
